// File: rtl/tdnn_pkg.sv
// Shared TDNN constants: coefficient geometry, bank index type, layer offsets, bank FSM states.
package tdnn_pkg;

  localparam int unsigned WEIGHT_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH   = 16;
  localparam int unsigned DEPTH        = 1200;
  localparam int unsigned NUM_BANKS    = 4;
  localparam int unsigned BANK_W       = 2;

  typedef logic [BANK_W-1:0] bank_t;

  // Word offsets of each layer's coefficients inside one bank
  localparam int unsigned W1_BASE = 0;
  localparam int unsigned W2_BASE = 576;
  localparam int unsigned W3_BASE = 1088;
  localparam int unsigned B1_BASE = 1120;
  localparam int unsigned B2_BASE = 1152;
  localparam int unsigned B3_BASE = 1184;

  typedef enum logic [BANK_W-1:0] {
    NORMAL = 2'd0,
    COLD   = 2'd1,
    HOT    = 2'd2,
    SPARE  = 2'd3
  } temp_bank_e;

  typedef enum logic {
    ST_ACTIVE  = 1'b0,
    ST_PENDING = 1'b1
  } bank_state_e;

endpackage

// File: rtl/tdnn_weight_ram.sv
// Flat coefficient RAM: one write port, registered read port with zero-forcing,
// plus a host readback port when TDNN_WEIGHT_BANK_READBACK_EN is defined.
module tdnn_weight_ram #(
  parameter int unsigned W     = 16,
  parameter int unsigned WORDS = 4800,
  parameter int unsigned IDX_W = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  input  logic             rzero_i,
  output logic [W-1:0]     rdata_o
`ifdef TDNN_WEIGHT_BANK_READBACK_EN
  ,
  input  logic             rb_en_i,
  input  logic [IDX_W-1:0] rb_addr_i,
  input  logic             rb_zero_i,
  output logic [W-1:0]     rb_data_o
`endif
);

  logic [W-1:0] mem_q [WORDS];

  // Storage has no reset; contents come from the write port or a preload
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        rdata_o <= '0;
    else if (rzero_i) rdata_o <= '0;
    else              rdata_o <= mem_q[raddr_i];
  end

`ifdef TDNN_WEIGHT_BANK_READBACK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)        rb_data_o <= '0;
    else if (rb_en_i) rb_data_o <= rb_zero_i ? '0 : mem_q[rb_addr_i];
  end
`endif

endmodule

// File: rtl/tdnn_weight_bank.sv
// Temperature-banked TDNN weight store with idle-only bank switching and protected writes.
// Optional host readback port: define TDNN_WEIGHT_BANK_READBACK_EN.
module tdnn_weight_bank import tdnn_pkg::*; #(
  parameter int unsigned WEIGHT_WIDTH = tdnn_pkg::WEIGHT_WIDTH,
  parameter int unsigned ADDR_WIDTH   = tdnn_pkg::ADDR_WIDTH,
  parameter int unsigned DEPTH        = tdnn_pkg::DEPTH,
  parameter int unsigned NUM_BANKS    = tdnn_pkg::NUM_BANKS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic        [ADDR_WIDTH-1:0]   weight_addr,
  output logic signed [WEIGHT_WIDTH-1:0] weight_data,
  input  bank_t                          bank_sel_req,
  input  logic                           gen_busy,
  output bank_t                          active_bank,
  output logic                           switch_pending,
  input  logic                           wr_en,
  input  bank_t                          wr_bank,
  input  logic        [ADDR_WIDTH-1:0]   wr_addr,
  input  logic        [WEIGHT_WIDTH-1:0] wr_data,
  output logic                           wr_ack,
  output logic                           wr_err,
  output logic                           rd_oob
`ifdef TDNN_WEIGHT_BANK_READBACK_EN
  ,
  input  logic                           rb_en,
  input  bank_t                          rb_bank,
  input  logic        [ADDR_WIDTH-1:0]   rb_addr,
  output logic        [WEIGHT_WIDTH-1:0] rb_data,
  output logic                           rb_valid
`endif
);

  localparam int unsigned MEM_WORDS = NUM_BANKS * DEPTH;
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);

  bank_state_e      state_q;
  logic             switch_req_c;
  logic             switch_now_c;
  logic             wr_ok_c;
  logic             rd_oob_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic [IDX_W-1:0] wr_idx_c;

  // Write protection sees the pre-edge bank and request, so a bank being switched in is locked
  always_comb begin
    switch_req_c = (bank_sel_req != active_bank);
    switch_now_c = switch_req_c && !gen_busy;
    rd_oob_c     = (weight_addr >= ADDR_WIDTH'(DEPTH));
    rd_idx_c     = IDX_W'(active_bank) * IDX_W'(DEPTH) + IDX_W'(weight_addr);
    wr_idx_c     = IDX_W'(wr_bank) * IDX_W'(DEPTH) + IDX_W'(wr_addr);
    wr_ok_c      = wr_en && (wr_addr < ADDR_WIDTH'(DEPTH)) && (wr_bank != active_bank)
                   && !((wr_bank == bank_sel_req) && ((state_q == ST_PENDING) || switch_now_c));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_ACTIVE;
      active_bank    <= '0;
      switch_pending <= 1'b0;
      wr_ack         <= 1'b0;
      wr_err         <= 1'b0;
      rd_oob         <= 1'b0;
    end else begin
      wr_ack <= wr_ok_c;
      wr_err <= wr_en && !wr_ok_c;
      if (rd_oob_c) rd_oob <= 1'b1;
      case (state_q)
        ST_ACTIVE: begin
          if (switch_now_c) begin
            active_bank <= bank_sel_req;
          end else if (switch_req_c) begin
            state_q        <= ST_PENDING;
            switch_pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (!switch_req_c) begin
            state_q        <= ST_ACTIVE;
            switch_pending <= 1'b0;
          end else if (!gen_busy) begin
            active_bank    <= bank_sel_req;
            state_q        <= ST_ACTIVE;
            switch_pending <= 1'b0;
          end
        end
        default: begin
          state_q        <= ST_ACTIVE;
          switch_pending <= 1'b0;
        end
      endcase
    end
  end

`ifdef TDNN_WEIGHT_BANK_READBACK_EN
  logic [IDX_W-1:0] rb_idx_c;
  logic             rb_zero_c;

  always_comb begin
    rb_idx_c  = IDX_W'(rb_bank) * IDX_W'(DEPTH) + IDX_W'(rb_addr);
    rb_zero_c = (rb_addr >= ADDR_WIDTH'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) rb_valid <= 1'b0;
    else     rb_valid <= rb_en;
  end
`endif

  tdnn_weight_ram #(
    .W     (WEIGHT_WIDTH),
    .WORDS (MEM_WORDS),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (wr_ok_c && !rst),
    .waddr_i   (wr_idx_c),
    .wdata_i   (wr_data),
    .raddr_i   (rd_idx_c),
    .rzero_i   (rd_oob_c),
    .rdata_o   (weight_data)
`ifdef TDNN_WEIGHT_BANK_READBACK_EN
    ,
    .rb_en_i   (rb_en),
    .rb_addr_i (rb_idx_c),
    .rb_zero_i (rb_zero_c),
    .rb_data_o (rb_data)
`endif
  );

endmodule

// File: tb/tb_tdnn_weight_bank.sv
// Table-driven bench for tdnn_weight_bank with a per-cycle expectation scoreboard.
module tb_tdnn_weight_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] weight_addr;
  logic signed [15:0] weight_data;
  logic [1:0]  bank_sel_req;
  logic        gen_busy;
  logic [1:0]  active_bank;
  logic        switch_pending;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        wr_err;
  logic        rd_oob;
`ifdef TDNN_WEIGHT_BANK_READBACK_EN
  logic        rb_en;
  logic [1:0]  rb_bank;
  logic [15:0] rb_addr;
  logic [15:0] rb_data;
  logic        rb_valid;
`endif

  always #5 clk = ~clk;

  tdnn_weight_bank dut (
    .clk            (clk),
    .rst            (rst),
    .weight_addr    (weight_addr),
    .weight_data    (weight_data),
    .bank_sel_req   (bank_sel_req),
    .gen_busy       (gen_busy),
    .active_bank    (active_bank),
    .switch_pending (switch_pending),
    .wr_en          (wr_en),
    .wr_bank        (wr_bank),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .wr_err         (wr_err),
    .rd_oob         (rd_oob)
`ifdef TDNN_WEIGHT_BANK_READBACK_EN
    ,
    .rb_en          (rb_en),
    .rb_bank        (rb_bank),
    .rb_addr        (rb_addr),
    .rb_data        (rb_data),
    .rb_valid       (rb_valid)
`endif
  );

  typedef struct {
    logic        rst;
    logic [15:0] waddr;
    logic [1:0]  req;
    logic        busy;
    logic        we;
    logic [1:0]  wb;
    logic [15:0] wa;
    logic [15:0] wdat;
    logic        chk_wd;
    logic [15:0] e_wd;
    logic [1:0]  e_ab;
    logic        e_sp;
    logic        e_ack;
    logic        e_err;
    logic        e_oob;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   vid    = 0;

  function automatic vec_t mk(input logic r, input logic [15:0] waddr, input logic [1:0] req,
                              input logic busy, input logic we, input logic [1:0] wb,
                              input logic [15:0] wa, input logic [15:0] wdat, input logic chk_wd,
                              input logic [15:0] e_wd, input logic [1:0] e_ab, input logic e_sp,
                              input logic e_ack, input logic e_err, input logic e_oob);
    vec_t v;
    v.rst = r; v.waddr = waddr; v.req = req; v.busy = busy;
    v.we = we; v.wb = wb; v.wa = wa; v.wdat = wdat;
    v.chk_wd = chk_wd; v.e_wd = e_wd; v.e_ab = e_ab; v.e_sp = e_sp;
    v.e_ack = e_ack; v.e_err = e_err; v.e_oob = e_oob;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL v%0d %s: got %h expected %h (t=%0t)", vid, nm, act, exp, $time);
    else passed++;
  endtask

  // Drive one cycle, queue its expectation, compare after the edge
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.rst; weight_addr = v.waddr; bank_sel_req = v.req; gen_busy = v.busy;
    wr_en = v.we; wr_bank = v.wb; wr_addr = v.wa; wr_data = v.wdat;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.chk_wd) chk("weight_data", 16'(weight_data), e.e_wd);
    chk("active_bank",    16'(active_bank),    16'(e.e_ab));
    chk("switch_pending", 16'(switch_pending), 16'(e.e_sp));
    chk("wr_ack",         16'(wr_ack),         16'(e.e_ack));
    chk("wr_err",         16'(wr_err),         16'(e.e_err));
    chk("rd_oob",         16'(rd_oob),         16'(e.e_oob));
    vid++;
  endtask

  initial begin
    rst = 1'b1; weight_addr = '0; bank_sel_req = '0; gen_busy = 1'b0;
    wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
`ifdef TDNN_WEIGHT_BANK_READBACK_EN
    rb_en = 1'b0; rb_bank = '0; rb_addr = '0;
`endif

    // reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0, 0, 0));
    // preload bank 1, switch to it idle, read back
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 5, 16'h1234,   0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 5, 1, 0, 0, 0, 0, 0,          0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 1, 0, 0, 0, 0, 0,          1, 16'h1234, 1, 0, 0, 0, 0));
    // active-bank write and out-of-range write rejected; content unchanged
    vecs.push_back(mk(0, 5, 1, 0, 1, 1, 5, 16'hBEEF,   1, 16'h1234, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 5, 1, 0, 1, 2, 1200, 16'h1111, 1, 16'h1234, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 5, 1, 0, 1, 2, 7, 16'h8001,   1, 16'h1234, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 5, 1, 0, 1, 2, 1199, 16'h0042, 1, 16'h1234, 1, 0, 1, 0, 0));
    // request bank 2 while busy for 20 cycles; pending-target write rejected, other bank accepted
    for (int k = 0; k < 20; k++)
      vecs.push_back(mk(0, 5, 2, 1, (k == 1) || (k == 2), (k == 2) ? 2'd3 : 2'd2,
                        (k == 2) ? 16'd3 : 16'd7, (k == 2) ? 16'h5555 : 16'hDEAD,
                        1, 16'h1234, 1, 1, k == 2, k == 1, 0));
    vecs.push_back(mk(0, 7, 2, 0, 0, 0, 0, 0,          0, 0, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 7, 2, 0, 0, 0, 0, 0,          1, 16'h8001, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1199, 2, 0, 0, 0, 0, 0,       1, 16'h0042, 2, 0, 0, 0, 0));
    // pending cancelled by returning the request to the active bank
    vecs.push_back(mk(0, 1199, 3, 1, 0, 0, 0, 0,       1, 16'h0042, 2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1199, 2, 1, 0, 0, 0, 0,       1, 16'h0042, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1199, 2, 1, 0, 0, 0, 0,       1, 16'h0042, 2, 0, 0, 0, 0));
    // write into the bank being switched in on the same edge is rejected
    vecs.push_back(mk(0, 7, 3, 0, 1, 3, 3, 16'h0BAD,   1, 16'h8001, 3, 0, 0, 1, 0));
    vecs.push_back(mk(0, 3, 3, 0, 0, 0, 0, 0,          1, 16'h5555, 3, 0, 0, 0, 0));
    // latest request wins when busy drops
    vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0,          1, 16'h5555, 3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 1, 0, 0, 0, 0,          1, 16'h5555, 3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 3, 1, 0, 0, 0, 0, 0,          1, 16'h5555, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 1, 0, 0, 0, 0, 0,          1, 16'h1234, 1, 0, 0, 0, 0));
    // out-of-range read: zero data, sticky flag
    vecs.push_back(mk(0, 1200, 1, 0, 0, 0, 0, 0,       1, 0, 1, 0, 0, 0, 1));
    for (int k = 0; k < 100; k++)
      vecs.push_back(mk(0, 5, 1, 0, 0, 0, 0, 0,        1, 16'h1234, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 16'hFFFF, 1, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // reset while pending, with a write in the reset cycle that must be dropped
    apply(mk(0, 5, 2, 1, 0, 0, 0, 0,                   1, 16'h1234, 1, 1, 0, 0, 1));
    apply(mk(1, 5, 2, 1, 1, 3, 3, 16'h0000,            1, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 3, 0, 0, 0, 0, 0,                   0, 0, 3, 0, 0, 0, 0));
    apply(mk(0, 3, 3, 0, 0, 0, 0, 0,                   1, 16'h5555, 3, 0, 0, 0, 0));

`ifdef TDNN_WEIGHT_BANK_READBACK_EN
    rb_en = 1'b1; rb_bank = 2'd1; rb_addr = 16'd5;
    apply(mk(0, 3, 3, 0, 0, 0, 0, 0,                   1, 16'h5555, 3, 0, 0, 0, 0));
    chk("rb_valid", 16'(rb_valid), 16'd1);
    chk("rb_data",  rb_data, 16'h1234);
    rb_bank = 2'd3; rb_addr = 16'd3;
    apply(mk(0, 3, 3, 0, 0, 0, 0, 0,                   1, 16'h5555, 3, 0, 0, 0, 0));
    chk("rb_data_active", rb_data, 16'h5555);
    rb_bank = 2'd2; rb_addr = 16'd1200;
    apply(mk(0, 3, 3, 0, 0, 0, 0, 0,                   1, 16'h5555, 3, 0, 0, 0, 0));
    chk("rb_valid_oob", 16'(rb_valid), 16'd1);
    chk("rb_data_oob",  rb_data, 16'h0000);
    rb_en = 1'b0;
    apply(mk(0, 3, 3, 0, 0, 0, 0, 0,                   1, 16'h5555, 3, 0, 0, 0, 0));
    chk("rb_valid_idle", 16'(rb_valid), 16'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tdnn_weight_bank.md
# tdnn_weight_bank

- Temperature-banked weight/bias store that answers the TDNN generator's `weight_addr` read requests with `weight_data`, one cycle later.
- Holds four Q1.15 weight sets (one per PA temperature bank), each 1200 words.
- Switches the active bank only while the generator is idle.
- Lets the host/loader rewrite inactive banks at runtime, so coefficient updates never corrupt an inference in flight.

## Interface
Parameters:
- `WEIGHT_WIDTH`, 16 — coefficient word width (Q1.15)
- `ADDR_WIDTH`, 16 — width of read/write address ports
- `DEPTH`, 1200 — words per bank (1120 weights + 50 biases, padded)
- `NUM_BANKS`, 4 — temperature banks; bank index width is 2

Ports:
- `clk` in 1 — single clock
- `rst` in 1 — synchronous, active-high reset
- `weight_addr` in ADDR_WIDTH — generator read address
- `weight_data` out WEIGHT_WIDTH — signed registered read data
- `bank_sel_req` in 2 — requested bank from the temperature controller
- `gen_busy` in 1 — generator `busy`; a bank switch is blocked while it is high
- `active_bank` out 2 — bank currently served
- `switch_pending` out 1 — a requested switch is waiting for the generator to go idle
- `wr_en` in 1 — write request (single-cycle strobe)
- `wr_bank` in 2 — target bank
- `wr_addr` in ADDR_WIDTH — target word
- `wr_data` in WEIGHT_WIDTH — data
- `wr_ack` out 1 — one-cycle pulse: write committed
- `wr_err` out 1 — one-cycle pulse: write rejected
- `rd_oob` out 1 — sticky flag: a generator read was out of range

## Operation
- Storage is NUM_BANKS×DEPTH words. Physical index = `active_bank*DEPTH + weight_addr`.
- Read path: on every edge, `weight_data <= mem[index]`.
  - If `weight_addr >= DEPTH`, `weight_data <= 0` and `rd_oob <= 1`.
  - `rd_oob` is cleared only by `rst`.
- Bank FSM has two states.
  - ACTIVE:
    - if `bank_sel_req != active_bank` and `gen_busy == 0`: switch at this edge (`active_bank <= bank_sel_req`), stay ACTIVE.
    - if `bank_sel_req != active_bank` and `gen_busy == 1`: go to PENDING, `switch_pending = 1`.
  - PENDING:
    - if `bank_sel_req == active_bank`: cancel, return to ACTIVE.
    - else if `gen_busy == 0`: `active_bank <= bank_sel_req`, sampled at that edge (latest request wins), return to ACTIVE.
- Write rules:
  - A write is accepted when `wr_en`, `wr_addr < DEPTH`, `wr_bank != active_bank`, and not (PENDING and `wr_bank == bank_sel_req`).
  - Otherwise it is rejected and memory is unchanged.
  - The protection check uses the pre-edge `active_bank` and `bank_sel_req`.
  - A write to bank B in the same cycle that a switch into B is decided is rejected.
- Every `wr_en` cycle produces exactly one of `wr_ack` / `wr_err` on the following cycle. There is no backpressure; back-to-back writes are allowed.
- Memory contents are not reset. Preload comes via the write port, or `$readmemh` in simulation.

## Timing
- Read latency is 1: the address sampled at edge N appears on `weight_data` after edge N, and is used by the generator at edge N+1.
- A bank switch decided at edge N affects reads sampled from edge N+1 onward.
- A write committed at edge N is readable by an address sampled at edge N+1 or later.
- Reset values: `weight_data` = 0, `active_bank` = 0, `switch_pending` = 0, `wr_ack` = 0, `wr_err` = 0, `rd_oob` = 0, FSM = ACTIVE.
- Reset mid-switch: the pending request is dropped and bank 0 becomes active. Any write presented in the `rst` cycle is ignored and produces no ack or err.
- `bank_sel_req` may change every cycle; no glitch reaches `active_bank` while `gen_busy` is high.

## Configuration
- `TDNN_WEIGHT_BANK_READBACK_EN` defined adds a host readback port:
  - ports: `rb_en` in, `rb_bank` in 2, `rb_addr` in ADDR_WIDTH, `rb_data` out, `rb_valid` out;
  - any bank may be read, including the active one;
  - `rb_data` and `rb_valid` appear 1 cycle after `rb_en`;
  - out-of-range reads return 0 with `rb_valid = 1`;
  - reset values: `rb_data` = 0, `rb_valid` = 0.
- Undefined: these ports and the second read port do not exist.

## Structure
- Shared package `tdnn_pkg` holds:
  - WEIGHT_WIDTH, DEPTH, NUM_BANKS;
  - bank index type;
  - layer base offsets: W1 = 0, W2 = 576, W3 = 1088, B1 = 1120, B2 = 1152, B3 = 1184;
  - bank enum NORMAL = 0, COLD = 1, HOT = 2, SPARE = 3.
- One sub-module, `tdnn_weight_ram`: a synchronous RAM with one write port and one or two read ports (second read port only with READBACK_EN). The FSM and protection logic live in the top module.

## Test plan
- Reset, write bank 1 addr 5 = 0x1234, then request bank 1 with `gen_busy` = 0 → switch at the next edge; `weight_addr` = 5 returns 0x1234 one cycle later.
- Request bank 2 while `gen_busy` = 1 for 20 cycles → `switch_pending` = 1 throughout and `active_bank` stays 1; drop `gen_busy` → `active_bank` = 2 at that edge.
- While PENDING toward bank 2, write bank 2 → `wr_err`; write bank 3 → `wr_ack`; return `bank_sel_req` to 1 → cancelled, `switch_pending` = 0.
- Write the active bank, or `wr_addr` = 1200 → `wr_err` pulse and memory unchanged (checked via readback when enabled).
- `weight_addr` = 0xFFFF → `weight_data` = 0 and `rd_oob` = 1, still set after 100 cycles; assert `rst` → `rd_oob` = 0.
- Assert `rst` during PENDING → `active_bank` = 0, `switch_pending` = 0, no `wr_ack` for a write in the `rst` cycle.
